// File: rtl/instruction_fetch_pkg.sv
// rtl/instruction_fetch_pkg.sv - shared fetch-stage constants, state encoding and helpers
// Purpose: reset PC default, fetch FSM encoding and instruction field positions.
// Ports: none (package).
package instruction_fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Instruction field positions consumed by instruction_control.
  localparam int OPCODE_LSB = 0;
  localparam int OPCODE_MSB = 6;
  localparam int FUNCT3_LSB = 12;
  localparam int FUNCT3_MSB = 14;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } fetch_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// rtl/instruction_fetch_if.sv - fetch stage bundle: imem request/response plus decode handoff
// Purpose: groups the instruction-memory handshake and the decode-facing signals.
// Modports: master = fetch stage, slave = memory/decode environment.
interface instruction_fetch_if;
  logic        ImemReqValid;
  logic [31:0] ImemReqAddr;
  logic        ImemReqReady;
  logic        ImemRespValid;
  logic [31:0] ImemRespData;
  logic        Stall;
  logic        Redirect;
  logic [31:0] RedirectPC;
  logic        InstrValid;
  logic [31:0] Instr;
  logic [31:0] InstrPC;
  logic [31:0] InstrPCPlus4;
  logic [6:0]  Opcode;
  logic [2:0]  Funct3;

  modport master (
    output ImemReqValid, ImemReqAddr, InstrValid, Instr, InstrPC, InstrPCPlus4, Opcode, Funct3,
    input  ImemReqReady, ImemRespValid, ImemRespData, Stall, Redirect, RedirectPC
  );

  modport slave (
    input  ImemReqValid, ImemReqAddr, InstrValid, Instr, InstrPC, InstrPCPlus4, Opcode, Funct3,
    output ImemReqReady, ImemRespValid, ImemRespData, Stall, Redirect, RedirectPC
  );
endinterface

// File: rtl/instruction_fetch_fetch_buffer.sv
// rtl/instruction_fetch_fetch_buffer.sv - 2-entry in-order buffer (output register + skid)
// Purpose: holds fetched words for decode; the output register is what decode sees.
// Ports: clk, rst (sync, active-high), flush, push/push_instr/push_pc, pop,
//        valid (output register occupied), full (skid occupied), instr/pc (output register).
module fetch_buffer (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        push,
  input  logic [31:0] push_instr,
  input  logic [31:0] push_pc,
  input  logic        pop,
  output logic        valid,
  output logic        full,
  output logic [31:0] instr,
  output logic [31:0] pc
);

  logic        out_valid_q, out_valid_d;
  logic [31:0] out_instr_q, out_instr_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic        skid_valid_q, skid_valid_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc_q, skid_pc_d;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_instr_d  = out_instr_q;
    out_pc_d     = out_pc_q;
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (pop) begin
      if (skid_valid_q) begin
        // Older skid word advances; a same-cycle push lands behind it.
        out_valid_d  = 1'b1;
        out_instr_d  = skid_instr_q;
        out_pc_d     = skid_pc_q;
        skid_valid_d = push;
        if (push) begin
          skid_instr_d = push_instr;
          skid_pc_d    = push_pc;
        end
      end else if (push) begin
        out_valid_d = 1'b1;
        out_instr_d = push_instr;
        out_pc_d    = push_pc;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (push) begin
      if (!out_valid_q) begin
        out_valid_d = 1'b1;
        out_instr_d = push_instr;
        out_pc_d    = push_pc;
      end else begin
        skid_valid_d = 1'b1;
        skid_instr_d = push_instr;
        skid_pc_d    = push_pc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_instr_q  <= '0;
      out_pc_q     <= '0;
      skid_valid_q <= 1'b0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_instr_q  <= out_instr_d;
      out_pc_q     <= out_pc_d;
      skid_valid_q <= skid_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

  assign valid = out_valid_q;
  assign full  = skid_valid_q;
  assign instr = out_instr_q;
  assign pc    = out_pc_q;

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - instruction fetch stage with one outstanding imem request
// Purpose: issues sequential word fetches, buffers returned words for decode, handles redirects.
// Ports: Clk, Reset (sync, active-high), bus (instruction_fetch_if.master: imem request/response,
//        Stall/Redirect/RedirectPC from the core, InstrValid/Instr/InstrPC/InstrPCPlus4/Opcode/Funct3 to decode).
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input logic                 Clk,
  input logic                 Reset,
  instruction_fetch_if.master bus
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  inflight_pc_q, inflight_pc_d;
  logic [31:0]  redir_pc_q, redir_pc_d;
  logic         redir_pend_q, redir_pend_d;

  logic         buf_valid, buf_full, space, req_valid, accept, resp_push, pop;
  logic [31:0]  buf_instr, buf_pc, redirect_tgt;

  assign redirect_tgt = word_align(bus.RedirectPC);
  assign space        = !buf_full && !(buf_valid && bus.Stall);
  // Issuing from WAIT on the response cycle keeps a zero-wait memory at one word per cycle.
  assign req_valid    = !Reset && ((state_q == REQ) ||
                        (state_q == WAIT && bus.ImemRespValid && space && !bus.Redirect));
  assign accept       = req_valid && bus.ImemReqReady;
  assign resp_push    = (state_q == WAIT) && bus.ImemRespValid && !bus.Redirect;
  assign pop          = buf_valid && !bus.Stall;

  fetch_buffer u_fetch_buffer (
    .clk        (Clk),
    .rst        (Reset),
    .flush      (bus.Redirect),
    .push       (resp_push),
    .push_instr (bus.ImemRespData),
    .push_pc    (inflight_pc_q),
    .pop        (pop),
    .valid      (buf_valid),
    .full       (buf_full),
    .instr      (buf_instr),
    .pc         (buf_pc)
  );

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    redir_pc_d    = redir_pc_q;
    redir_pend_d  = redir_pend_q;
    inflight_pc_d = accept ? pc_q : inflight_pc_q;
    unique case (state_q)
      IDLE: begin
        if (bus.Redirect) begin
          pc_d    = redirect_tgt;
          state_d = REQ;
        end else if (space) begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (accept) begin
          redir_pend_d = 1'b0;
          if (bus.Redirect) begin
            pc_d    = redirect_tgt;
            state_d = DROP;
          end else if (redir_pend_q) begin
            pc_d    = redir_pc_q;
            state_d = DROP;
          end else begin
            pc_d    = pc_q + 32'd4;
            state_d = WAIT;
          end
        end else if (bus.Redirect) begin
          // The presented address must stay put; remember the target until acceptance.
          redir_pend_d = 1'b1;
          redir_pc_d   = redirect_tgt;
        end
      end
      WAIT: begin
        if (bus.Redirect) begin
          pc_d    = redirect_tgt;
          // A response in the redirect cycle is the outstanding one, so nothing is left to drop.
          state_d = bus.ImemRespValid ? REQ : DROP;
        end else if (bus.ImemRespValid) begin
          if (accept) begin
            pc_d    = pc_q + 32'd4;
            state_d = WAIT;
          end else if (space) begin
            state_d = REQ;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DROP: begin
        if (bus.Redirect) begin
          pc_d = redirect_tgt;
        end
        if (bus.ImemRespValid) begin
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      inflight_pc_q <= '0;
      redir_pc_q    <= '0;
      redir_pend_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inflight_pc_q <= inflight_pc_d;
      redir_pc_q    <= redir_pc_d;
      redir_pend_q  <= redir_pend_d;
    end
  end

  assign bus.ImemReqValid = req_valid;
  assign bus.ImemReqAddr  = pc_q;
  assign bus.InstrValid   = buf_valid && !Reset;
  assign bus.Instr        = buf_instr;
  assign bus.InstrPC      = buf_pc;
  assign bus.InstrPCPlus4 = Reset ? 32'd0 : buf_pc + 32'd4;
  assign bus.Opcode       = buf_instr[OPCODE_MSB:OPCODE_LSB];
  assign bus.Funct3       = buf_instr[FUNCT3_MSB:FUNCT3_LSB];

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - self-checking bench for instruction_fetch
module tb_instruction_fetch;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  instruction_fetch_if bus();

  instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic        stall_i, redirect_i, ready_i;
  logic [31:0] redirect_pc_i;
  int          lat_i;
  bit          rand_lat;

  bit          mem_pend;
  logic [31:0] mem_addr;
  int          mem_due;
  int          cyc;

  logic        s_rv, s_iv;
  logic [31:0] s_ra, s_ipc, s_instr, s_plus4;
  logic [6:0]  s_op;
  logic [2:0]  s_f3;

  logic        p_rv, p_ready, p_iv, p_stall, p_redirect;
  logic [31:0] p_ra, p_ipc, p_instr;

  logic [31:0] exp_pc, fetch_exp, stale_addr;
  bit          stale;
  int          consumed;
  bit          wrap_armed, saw_wrap;

  bit          logging;
  int          k;
  logic        log_rv [0:63];
  logic        log_iv [0:63];
  logic [31:0] log_ra [0:63];
  logic [31:0] log_ipc[0:63];

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic run_cycle();
    logic        resp;
    logic [31:0] w, tgt;
    resp = mem_pend && (cyc == mem_due);
    bus.ImemRespValid = resp;
    bus.ImemRespData  = resp ? memf(mem_addr) : $urandom;
    bus.Stall         = stall_i;
    bus.Redirect      = redirect_i;
    bus.RedirectPC    = redirect_pc_i;
    bus.ImemReqReady  = ready_i;
    #1;
    s_rv = bus.ImemReqValid; s_ra = bus.ImemReqAddr;
    s_iv = bus.InstrValid;   s_ipc = bus.InstrPC; s_instr = bus.Instr;
    s_plus4 = bus.InstrPCPlus4; s_op = bus.Opcode; s_f3 = bus.Funct3;

    if (!Reset) begin
      if (p_redirect) begin
        check_val("flush_after_redirect", 32'(s_iv), 32'd0);
      end else if (p_iv && p_stall) begin
        check_val("stall_hold_valid", 32'(s_iv), 32'd1);
        check_val("stall_hold_pc", s_ipc, p_ipc);
        check_val("stall_hold_instr", s_instr, p_instr);
      end
      if (p_rv && !p_ready) begin
        check_val("req_hold_valid", 32'(s_rv), 32'd1);
        check_val("req_hold_addr", s_ra, p_ra);
      end
      if (s_iv && !stall_i && !redirect_i) begin
        w = memf(exp_pc);
        check_val("instr_pc", s_ipc, exp_pc);
        check_val("instr_word", s_instr, w);
        check_val("instr_pc_plus4", s_plus4, exp_pc + 32'd4);
        check_val("opcode", 32'(s_op), 32'(w[6:0]));
        check_val("funct3", 32'(s_f3), 32'(w[14:12]));
        exp_pc = exp_pc + 32'd4;
        consumed++;
      end
      if (s_rv && ready_i) begin
        check_val("one_outstanding", 32'(mem_pend && !resp), 32'd0);
        if (stale) begin
          check_val("stale_addr", s_ra, stale_addr);
          stale = 1'b0;
        end else begin
          check_val("fetch_addr", s_ra, fetch_exp);
          fetch_exp = fetch_exp + 32'd4;
        end
        if (wrap_armed && s_ra == 32'd0) saw_wrap = 1'b1;
      end
      if (redirect_i) begin
        tgt = redirect_pc_i & 32'hFFFF_FFFC;
        if (s_rv && !ready_i && !stale) begin
          stale = 1'b1;
          stale_addr = s_ra;
        end
        fetch_exp = tgt;
        exp_pc    = tgt;
      end
    end

    if (resp) mem_pend = 1'b0;
    if (Reset) begin
      mem_pend = 1'b0;
      exp_pc = 32'd0; fetch_exp = 32'd0; stale = 1'b0;
    end else if (s_rv && ready_i) begin
      mem_pend = 1'b1;
      mem_addr = s_ra;
      mem_due  = cyc + (rand_lat ? int'($urandom_range(1, 3)) : lat_i);
    end

    if (logging && k < 64) begin
      log_rv[k] = s_rv; log_ra[k] = s_ra; log_iv[k] = s_iv; log_ipc[k] = s_ipc;
      k++;
    end

    p_rv = Reset ? 1'b0 : s_rv;   p_ra = s_ra;   p_ready = ready_i;
    p_iv = Reset ? 1'b0 : s_iv;   p_stall = stall_i;
    p_redirect = Reset ? 1'b0 : redirect_i;
    p_ipc = s_ipc; p_instr = s_instr;
    @(posedge Clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    Reset = 1'b1; redirect_i = 1'b0; ready_i = 1'b1;
    run_cycle();
    check_val("reset_req_valid", 32'(s_rv), 32'd0);
    check_val("reset_instr_valid", 32'(s_iv), 32'd0);
    run_cycle();
    check_val("reset_instr", s_instr, 32'd0);
    check_val("reset_instr_pc", s_ipc, 32'd0);
    check_val("reset_instr_pc_plus4", s_plus4, 32'd0);
    Reset = 1'b0; stall_i = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; ready_i = 1'b1;
    redirect_pc_i = 32'd0; lat_i = 1; rand_lat = 1'b0;
    mem_pend = 1'b0; mem_addr = '0; mem_due = 0; cyc = 0;
    p_rv = 0; p_ready = 1; p_iv = 0; p_stall = 0; p_redirect = 0;
    p_ra = '0; p_ipc = '0; p_instr = '0;
    exp_pc = '0; fetch_exp = '0; stale = 0; stale_addr = '0; consumed = 0;
    wrap_armed = 0; saw_wrap = 0; logging = 0; k = 0;
    @(posedge Clk);
    #1;
    do_reset();

    // Directed timeline from reset release (index = cycle after release).
    logging = 1'b1; k = 0;
    for (int c = 0; c < 28; c++) begin
      stall_i       = (c >= 5 && c <= 7);
      ready_i       = !(c >= 20 && c <= 23);
      redirect_i    = (c == 12 || c == 16 || c == 22);
      redirect_pc_i = (c == 12) ? 32'h0000_0100 : (c == 16) ? 32'h0000_0206 : 32'h0000_0300;
      lat_i         = (c == 11) ? 2 : (c == 27) ? 3 : 1;
      run_cycle();
    end
    logging = 1'b0;
    redirect_i = 1'b0; ready_i = 1'b1; lat_i = 1;

    check_val("c0_no_req", 32'(log_rv[0]), 32'd0);
    for (int c = 1; c <= 3; c++) begin
      check_val("startup_req_valid", 32'(log_rv[c]), 32'd1);
      check_val("startup_req_addr", log_ra[c], 32'(4 * (c - 1)));
    end
    check_val("c2_no_instr", 32'(log_iv[2]), 32'd0);
    for (int c = 3; c <= 5; c++) begin
      check_val("startup_instr_valid", 32'(log_iv[c]), 32'd1);
      check_val("startup_instr_pc", log_ipc[c], 32'(4 * (c - 3)));
    end
    for (int c = 5; c <= 8; c++) begin
      check_val("stall_pc8", log_ipc[c], 32'h8);
      check_val("stall_no_req", 32'(log_rv[c]), 32'd0);
    end
    check_val("skid_pc12_valid", 32'(log_iv[9]), 32'd1);
    check_val("skid_pc12", log_ipc[9], 32'hC);
    check_val("skid_no_req", 32'(log_rv[9]), 32'd0);
    check_val("after_stall_req", 32'(log_rv[10]), 32'd1);
    check_val("after_stall_addr", log_ra[10], 32'h10);
    check_val("wait_redirect_no_req", 32'(log_rv[12]), 32'd0);
    check_val("drop_no_req", 32'(log_rv[13]), 32'd0);
    check_val("drop_no_instr", 32'(log_iv[13]), 32'd0);
    check_val("redirect_req_valid", 32'(log_rv[14]), 32'd1);
    check_val("redirect_req_addr", log_ra[14], 32'h100);
    check_val("redirect_instr_valid", 32'(log_iv[16]), 32'd1);
    check_val("redirect_instr_pc", log_ipc[16], 32'h100);
    check_val("resp_redirect_no_req", 32'(log_rv[16]), 32'd0);
    check_val("unaligned_redirect_req", 32'(log_rv[17]), 32'd1);
    check_val("unaligned_redirect_addr", log_ra[17], 32'h204);
    check_val("unaligned_redirect_no_instr", 32'(log_iv[17]), 32'd0);
    for (int c = 20; c <= 24; c++) begin
      check_val("not_ready_valid", 32'(log_rv[c]), 32'd1);
      check_val("not_ready_addr", log_ra[c], 32'h210);
    end
    check_val("stale_drop_no_req", 32'(log_rv[25]), 32'd0);
    check_val("stale_target_req", 32'(log_rv[26]), 32'd1);
    check_val("stale_target_addr", log_ra[26], 32'h300);
    check_val("pre_reset_instr_valid", 32'(log_iv[27]), 32'd0);

    // Reset while a request is outstanding and decode is stalled on PC 0x300.
    stall_i = 1'b1;
    run_cycle();
    check_val("pre_reset_pc300_valid", 32'(s_iv), 32'd1);
    check_val("pre_reset_pc300", s_ipc, 32'h300);
    do_reset();
    run_cycle();
    check_val("post_reset_instr_valid", 32'(s_iv), 32'd0);
    check_val("post_reset_req_valid", 32'(s_rv), 32'd0);
    run_cycle();
    check_val("post_reset_req", 32'(s_rv), 32'd1);
    check_val("post_reset_addr", s_ra, 32'h0);

    // Fetch PC wrap past 0xFFFF_FFFC.
    wrap_armed = 1'b1;
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFF9;
    run_cycle();
    redirect_i = 1'b0;
    for (int c = 0; c < 12; c++) run_cycle();
    check_val("wrap_to_zero", 32'(saw_wrap), 32'd1);
    wrap_armed = 1'b0;

    // Randomized traffic.
    rand_lat = 1'b1;
    consumed = 0;
    for (int c = 0; c < 4000; c++) begin
      stall_i    = ($urandom % 100) < 30;
      ready_i    = ($urandom % 100) < 70;
      redirect_i = ($urandom % 100) < 3;
      redirect_pc_i = (($urandom % 4) == 0) ? (32'hFFFF_FFF0 | ($urandom % 16)) : $urandom;
      run_cycle();
    end
    check_val("random_progress", 32'(consumed > 400), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
